// File: rtl/mmio_uart_tx_if.sv
// Core data-bus view of the memory-mapped UART transmitter.
// The master drives store traffic; the slave returns the decode hit and read data.
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        sel;
    logic [31:0] rd;

    modport master (output we, a, wd, input sel, rd);
    modport slave  (input we, a, wd, output sel, rd);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA are queued in a small FIFO
// and shifted out LSB first; STATUS reports FIFO level, sticky overflow and busy.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic [BW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, shreg_d;
    logic          tx_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf, full, empty, push, pop, wr_data, wr_status, bit_end;
    logic [4:0]    count5;
    logic [31:0]   status;
    logic          unused_bus;

    assign busy    = (state != IDLE);
    assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        bus.sel   = (bus.a[31:3] == BASE_ADDR[31:3]);
        full      = (count == CW'(FIFO_DEPTH));
        empty     = (count == '0);
        wr_data   = bus.we && bus.sel && !bus.a[2];
        wr_status = bus.we && bus.sel && bus.a[2];
        // full is the pre-edge value, so a pop in the same cycle never admits the write
        push      = wr_data && !full;
        count5    = 5'(count);
        status    = {24'd0, count5[3:0], busy, ovf, empty, full};
        bus.rd    = (bus.sel && bus.a[2]) ? status : 32'd0;
    end

    assign unused_bus = &{1'b0, bus.wd[31:8], bus.a[1:0], count5[4]};

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shreg_d = shreg;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_cnt + BW'(1);
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_cnt + BW'(1);
                if (bit_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg[7:1]};
                    bit_d   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            default: begin
                baud_d = baud_cnt + BW'(1);
                if (bit_end) begin
                    baud_d = '0;
                    // back-to-back frames: next start bit follows the stop bit directly
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            tx       <= tx_d;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
            if (wr_data && full)                ovf <= 1'b1;
            else if (wr_status && bus.wd[2])    ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_d;
        if (push) mem[wr_ptr] <= bus.wd[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, checked every
// cycle against a frame-timeline model of the serial line and STATUS register.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx, busy;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    endtask

    // Each accepted byte becomes a frame on a timeline: pushed at edge m_push,
    // occupying the line from edge m_start for FRAME cycles.
    int         m_push[$];
    int         m_start[$];
    logic [7:0] m_data[$];
    bit         m_ovf = 1'b0;
    int         m_last_end = 0;
    bit         chk_en = 1'b0;

    function automatic int cnt_at(int t);
        int c = 0;
        foreach (m_push[i]) begin
            if (m_push[i] <= t) c++;
            if (m_start[i] <= t) c--;
        end
        return c;
    endfunction

    function automatic int frame_at(int t);
        foreach (m_start[i])
            if (t >= m_start[i] && t < m_start[i] + FRAME) return i;
        return -1;
    endfunction

    function automatic logic exp_tx(int t);
        int f = frame_at(t);
        int k;
        if (f < 0) return 1'b1;
        k = (t - m_start[f]) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_data[f][k-1];
    endfunction

    function automatic logic [31:0] exp_status(int t);
        int         c  = cnt_at(t);
        logic [3:0] c4 = 4'(c);
        return {24'd0, c4, frame_at(t) >= 0, m_ovf, c == 0, c == DEPTH};
    endfunction

    // One clock: check the state left by the previous edge, then apply inputs for the next.
    task automatic step(input bit w, input logic [31:0] addr, input logic [31:0] data, input bit rn);
        int E;
        int c;
        int st;
        bit s;
        bus.we = w;
        bus.a  = addr;
        bus.wd = data;
        reset  = rn;
        #1;
        s = (addr[31:3] == BASE[31:3]);
        if (chk_en) begin
            chk("tx", 32'(tx), 32'(exp_tx(cyc)));
            chk("busy", 32'(busy), 32'(frame_at(cyc) >= 0));
            chk("sel", 32'(bus.sel), 32'(s));
            chk("rd", bus.rd, (s && addr[2]) ? exp_status(cyc) : 32'd0);
        end
        E = cyc + 1;
        if (!rn) begin
            m_push.delete();
            m_start.delete();
            m_data.delete();
            m_ovf = 1'b0;
            m_last_end = 0;
        end else if (w && s) begin
            if (!addr[2]) begin
                c = cnt_at(E - 1);
                if (c == DEPTH) m_ovf = 1'b1;
                else begin
                    st = (E + 1 > m_last_end) ? E + 1 : m_last_end;
                    m_push.push_back(E);
                    m_start.push_back(st);
                    m_data.push_back(data[7:0]);
                    m_last_end = st + FRAME;
                end
            end else if (data[2]) begin
                m_ovf = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, BASE + 32'd4, 32'd0, 1'b1);
    endtask

    initial begin
        int st;
        int r;
        logic [31:0] decoy [4];
        decoy[0] = 32'h0000_0060;
        decoy[1] = 32'h0000_0108;
        decoy[2] = 32'h0000_00FC;
        decoy[3] = 32'h8000_0104;
        bus.we = 1'b0;
        bus.a  = BASE + 32'd4;
        bus.wd = 32'd0;

        step(1'b0, BASE + 32'd4, 32'd0, 1'b0);
        step(1'b0, BASE + 32'd4, 32'd0, 1'b0);
        chk_en = 1'b1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status", bus.rd, 32'h2);
        idle(3);

        // single byte, upper store bits must be ignored
        step(1'b1, BASE, 32'hFFFF_FF55, 1'b1);
        idle(1);
        chk("single_start_bit", 32'(tx), 32'd0);
        idle(45);
        chk("single_done_status", bus.rd, 32'h2);

        step(1'b1, BASE, 32'h0000_00A5, 1'b1);
        step(1'b1, BASE, 32'h0000_003C, 1'b1);
        idle(2 * FRAME + 5);
        chk("b2b_done_status", bus.rd, 32'h2);

        for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'h11 + 32'(i), 1'b1);
        idle(1);
        chk("ovf_status", bus.rd, 32'h4D);
        step(1'b1, BASE + 32'd4, 32'h4, 1'b1);
        chk("ovf_clear_status", bus.rd, 32'h49);
        idle(5 * FRAME + 10);
        chk("ovf_drain_status", bus.rd, 32'h2);

        // reset during data bit 3
        step(1'b1, BASE, 32'h0000_0096, 1'b1);
        st = m_start[m_start.size() - 1];
        for (int i = 0; i < 200 && cyc < st + 4 * CPB + 1; i++) idle(1);
        step(1'b0, BASE + 32'd4, 32'd0, 1'b0);
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_status", bus.rd, 32'h2);
        idle(FRAME + 10);

        step(1'b1, 32'h0000_0060, 32'h77, 1'b1);
        step(1'b1, 32'h0000_0108, 32'h77, 1'b1);
        idle(1);
        chk("decode_status", bus.rd, 32'h2);
        idle(FRAME + 5);

        repeat (1500) begin
            r = $urandom_range(0, 99);
            if (r < 2)       step(1'b0, BASE + 32'd4, $urandom, 1'b0);
            else if (r < 12) step(1'b1, BASE | 32'($urandom_range(0, 3)), $urandom, 1'b1);
            else if (r < 15) step(1'b1, BASE + 32'd4, $urandom, 1'b1);
            else if (r < 18) step(1'b1, decoy[$urandom_range(0, 3)], $urandom, 1'b1);
            else             idle(1);
        end
        idle(5 * FRAME + 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
